// File: rtl/vga_scanout_fb.sv
// Pixel-write stream into an on-chip H_RES x V_RES x 3-bit frame buffer,
// scanned out as VGA with 2^SCALE_SHIFT x 2^SCALE_SHIFT pixel replication.
module vga_scanout_fb #(
    parameter int unsigned H_RES       = 160,
    parameter int unsigned V_RES       = 120,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter logic [2:0]  BG_COLOUR   = 3'b000,
    parameter int unsigned H_VIS       = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_VIS       = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       writeEn,
    output logic       busy,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic       vga_clk,
    output logic       frame_start
);

    localparam int unsigned FB_DEPTH = H_RES * V_RES;
    localparam int unsigned FB_AW    = $clog2(FB_DEPTH);
    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned CNT_W    = 10;
    localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0]  H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0]  V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0]  H_VIS_C  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0]  V_VIS_C  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0]  HS_FIRST = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0]  HS_LAST  = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0]  VS_FIRST = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0]  VS_LAST  = CNT_W'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_DEPTH - 1);
    localparam logic [ADDR_W-1:0] H_RES_A  = ADDR_W'(H_RES);
    localparam logic [7:0]        X_LIM    = 8'(H_RES);
    localparam logic [6:0]        Y_LIM    = 7'(V_RES);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_clr_addr;
    logic               r_busy;

    logic               r_pix_en;
    logic [CNT_W-1:0]   r_hcount;
    logic [CNT_W-1:0]   r_vcount;
    logic               r_frame_start;

    logic [2:0]         r_fb [FB_DEPTH];
    logic [2:0]         r_rd_data;

    logic               r_hs_d1;
    logic               r_vs_d1;
    logic               r_vis_d1;
    logic               r_hs;
    logic               r_vs;
    logic               r_blank_n;
    logic [7:0]         r_red;
    logic [7:0]         r_green;
    logic [7:0]         r_blue;

    logic               w_hs_raw;
    logic               w_vs_raw;
    logic               w_vis;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [FB_AW-1:0]   w_rd_idx;
    logic               w_clearing;
    logic               w_user_ok;
    logic               w_wr_en;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic [2:0]         w_wr_data;

    // Raw sync/visibility decode straight from the counters
    assign w_hs_raw  = !((r_hcount >= HS_FIRST) && (r_hcount <= HS_LAST));
    assign w_vs_raw  = !((r_vcount >= VS_FIRST) && (r_vcount <= VS_LAST));
    assign w_vis     = (r_hcount < H_VIS_C) && (r_vcount < V_VIS_C);
    assign w_rd_addr = ADDR_W'(r_vcount >> SCALE_SHIFT) * H_RES_A
                     + ADDR_W'(r_hcount >> SCALE_SHIFT);
    // Blanking addresses fall outside the buffer; their data is masked anyway
    assign w_rd_idx  = FB_AW'(w_vis ? w_rd_addr : '0);

    // Single write port shared by the clear sweep and the pixel stream
    assign w_clearing = (r_state == S_CLEAR);
    assign w_user_ok  = writeEn && !r_busy && (x < X_LIM) && (y < Y_LIM);
    assign w_wr_en    = !reset && (w_clearing || w_user_ok);
    assign w_wr_addr  = w_clearing ? r_clr_addr
                                   : ADDR_W'(y) * H_RES_A + ADDR_W'(x);
    assign w_wr_data  = w_clearing ? BG_COLOUR : colour;

    // Clear sweep: one background write per clk, then run forever
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
            r_busy     <= 1'b1;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clr_addr <= r_clr_addr + ADDR_W'(1);
                    if (r_clr_addr == CLR_LAST) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Pixel-enable divider and raster counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_en      <= 1'b0;
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_pix_en      <= ~r_pix_en;
            // Counters are stable across the idle half, so this lands on the h=0,v=0 tick
            r_frame_start <= !r_pix_en && (r_hcount == '0) && (r_vcount == '0);
            if (r_pix_en) begin
                if (r_hcount == H_LAST) begin
                    r_hcount <= '0;
                    r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + CNT_W'(1);
                end else begin
                    r_hcount <= r_hcount + CNT_W'(1);
                end
            end
        end
    end

    // Dual-port frame buffer; a same-cycle read of a written address sees old data
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_fb[FB_AW'(w_wr_addr)] <= w_wr_data;
        end
        if (r_pix_en) begin
            r_rd_data <= r_fb[w_rd_idx];
        end
    end

    // Two-tick alignment of sync/blank with the read data and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hs_d1   <= 1'b1;
            r_vs_d1   <= 1'b1;
            r_vis_d1  <= 1'b0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
            r_red     <= 8'h00;
            r_green   <= 8'h00;
            r_blue    <= 8'h00;
        end else if (r_pix_en) begin
            r_hs_d1   <= w_hs_raw;
            r_vs_d1   <= w_vs_raw;
            r_vis_d1  <= w_vis;
            r_hs      <= r_hs_d1;
            r_vs      <= r_vs_d1;
            r_blank_n <= r_vis_d1;
            r_red     <= r_vis_d1 ? {8{r_rd_data[2]}} : 8'h00;
            r_green   <= r_vis_d1 ? {8{r_rd_data[1]}} : 8'h00;
            r_blue    <= r_vis_d1 ? {8{r_rd_data[0]}} : 8'h00;
        end
    end

    assign busy        = r_busy;
    assign vga_r       = r_red;
    assign vga_g       = r_green;
    assign vga_b       = r_blue;
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign vga_blank_n = r_blank_n;
    assign vga_sync_n  = 1'b0;
    assign vga_clk     = r_pix_en;
    assign frame_start = r_frame_start;

endmodule
